// File: rtl/pipelined_decode_stage.sv
// WISC decode stage: instruction decode, 16-entry regfile, branch resolution, hazard stalls,
// internal ID/EX register and sticky HLT. Optional macro WB_BYPASS_EN forwards same-cycle WB data.
module pipelined_decode_stage #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid_i,
    input  logic [15:0]           if_inst_i,
    input  logic [DATA_W-1:0]     if_pc_next_i,
    input  logic                  if_pred_taken_i,
    input  logic [DATA_W-1:0]     if_pred_target_i,
    input  logic [2:0]            flags_i,
    input  logic                  ex_reg_wr_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_sets_flags_i,
    input  logic [3:0]            ex_rd_i,
    input  logic                  mem_mem_read_i,
    input  logic [3:0]            mem_rd_i,
    input  logic                  wb_wen_i,
    input  logic [3:0]            wb_rd_i,
    input  logic [DATA_W-1:0]     wb_data_i,
    output logic                  stall_o,
    output logic                  is_branch_o,
    output logic                  is_br_o,
    output logic                  actual_taken_o,
    output logic                  wen_btb_o,
    output logic                  wen_bht_o,
    output logic                  update_pc_o,
    output logic [DATA_W-1:0]     branch_target_o,
    output logic                  id_ex_valid_o,
    output logic [3*DATA_W+14:0]  id_ex_ex_o,
    output logic [DATA_W+1:0]     id_ex_mem_o,
    output logic [7:0]            id_ex_wb_o,
    output logic [DATA_W-1:0]     id_ex_pc_next_o,
    output logic                  halted_o
);

    localparam logic [3:0] OpAdd    = 4'h0;
    localparam logic [3:0] OpSub    = 4'h1;
    localparam logic [3:0] OpXor    = 4'h2;
    localparam logic [3:0] OpSll    = 4'h4;
    localparam logic [3:0] OpSra    = 4'h5;
    localparam logic [3:0] OpRor    = 4'h6;
    localparam logic [3:0] OpPaddsb = 4'h7;
    localparam logic [3:0] OpLw     = 4'h8;
    localparam logic [3:0] OpSw     = 4'h9;
    localparam logic [3:0] OpLlb    = 4'hA;
    localparam logic [3:0] OpLhb    = 4'hB;
    localparam logic [3:0] OpB      = 4'hC;
    localparam logic [3:0] OpBr     = 4'hD;
    localparam logic [3:0] OpPcs    = 4'hE;
    localparam logic [3:0] OpHlt    = 4'hF;

    localparam bit ZeroReg = (ZERO_REG != 0);

    typedef enum logic {StRun, StHalted} state_e;
    state_e state_q, state_d;

    logic [DATA_W-1:0] rf_q [16];

    logic [3:0]        opcode, rd, rs, rt, src1, src2;
    logic [2:0]        ccc;
    logic              use1, use2, nop, active;
    logic [DATA_W-1:0] rd1, rd2, imm, b_off, b_target, target;
    logic              alu_src, z_en, nv_en, reg_write, mem_to_reg, is_hlt, is_pcs;
    logic              mem_en, mem_wr;
    logic              wb_hit, ex_nz, mem_nz, load_use, b_haz, br_haz, wb_haz, stall;
    logic              taken, br_ok, capture;

    logic                 id_ex_valid_q;
    logic [3*DATA_W+14:0] id_ex_ex_d, id_ex_ex_q;
    logic [DATA_W+1:0]    id_ex_mem_d, id_ex_mem_q;
    logic [7:0]           id_ex_wb_d, id_ex_wb_q;
    logic [DATA_W-1:0]    id_ex_pc_next_q;

    assign opcode = if_inst_i[15:12];
    assign rd     = if_inst_i[11:8];
    assign rs     = if_inst_i[7:4];
    assign rt     = if_inst_i[3:0];
    assign ccc    = if_inst_i[11:9];

    // LLB/LHB merge into rd, SW stores rd: both read rd as a source.
    assign src1 = (opcode == OpLlb || opcode == OpLhb) ? rd : rs;
    assign src2 = (opcode == OpSw) ? rd : rt;
    assign use1 = (opcode <= OpLhb) || (opcode == OpBr);
    assign use2 = (opcode <= OpPaddsb) || (opcode == OpSw);

    assign alu_src    = opcode inside {OpSll, OpSra, OpRor, OpLw, OpSw, OpLlb, OpLhb};
    assign z_en       = opcode inside {OpAdd, OpSub, OpXor, OpSll, OpSra, OpRor};
    assign nv_en      = opcode inside {OpAdd, OpSub};
    assign reg_write  = (opcode <= OpLw) || (opcode inside {OpLlb, OpLhb, OpPcs});
    assign mem_to_reg = (opcode == OpLw);
    assign mem_en     = (opcode == OpLw) || (opcode == OpSw);
    assign mem_wr     = (opcode == OpSw);
    assign is_hlt     = (opcode == OpHlt);
    assign is_pcs     = (opcode == OpPcs);

    always_comb begin
        imm = '0;
        if (opcode == OpLw || opcode == OpSw) begin
            imm = {{(DATA_W-4){if_inst_i[3]}}, if_inst_i[3:0]};
        end else if (opcode inside {OpSll, OpSra, OpRor}) begin
            imm = {{(DATA_W-4){1'b0}}, if_inst_i[3:0]};
        end else if (opcode inside {OpLlb, OpLhb}) begin
            imm = {{(DATA_W-8){1'b0}}, if_inst_i[7:0]};
        end
    end

    // R0 is never written when hardwired, so plain reads of it return zero.
    assign wb_hit = wb_wen_i && (!ZeroReg || wb_rd_i != 4'd0);
    assign ex_nz  = !ZeroReg || ex_rd_i != 4'd0;
    assign mem_nz = !ZeroReg || mem_rd_i != 4'd0;

    always_comb begin
        rd1 = rf_q[src1];
        rd2 = rf_q[src2];
`ifdef WB_BYPASS_EN
        if (wb_hit && wb_rd_i == src1) rd1 = wb_data_i;
        if (wb_hit && wb_rd_i == src2) rd2 = wb_data_i;
`endif
    end

    assign load_use = ex_mem_read_i && ex_nz &&
                      ((use1 && ex_rd_i == src1) || (use2 && ex_rd_i == src2));
    assign b_haz    = (opcode == OpB) && ex_sets_flags_i;
    assign br_haz   = (opcode == OpBr) &&
                      ((ex_reg_wr_i && ex_nz && ex_rd_i == rs) ||
                       (mem_mem_read_i && mem_nz && mem_rd_i == rs));
`ifdef WB_BYPASS_EN
    assign wb_haz = 1'b0;
`else
    assign wb_haz = wb_hit && ((use1 && wb_rd_i == src1) || (use2 && wb_rd_i == src2));
`endif

    assign active = if_valid_i && (state_q == StRun);
    assign nop    = (if_inst_i == 16'h0000);
    assign stall  = active && !nop && (load_use || b_haz || br_haz || wb_haz);

    // flags_i = {Z, V, N}
    always_comb begin
        unique case (ccc)
            3'b000:  taken = !flags_i[2];
            3'b001:  taken = flags_i[2];
            3'b010:  taken = !flags_i[2] && !flags_i[0];
            3'b011:  taken = flags_i[0];
            3'b100:  taken = flags_i[2] || (!flags_i[2] && !flags_i[0]);
            3'b101:  taken = flags_i[0] || flags_i[2];
            3'b110:  taken = flags_i[1];
            default: taken = 1'b1;
        endcase
    end

    assign b_off    = {{(DATA_W-9){if_inst_i[8]}}, if_inst_i[8:0]};
    assign b_target = if_pc_next_i + {b_off[DATA_W-2:0], 1'b0};
    assign target   = (opcode == OpBr) ? rd1 : b_target;
    assign br_ok    = active && !stall && (opcode == OpB || opcode == OpBr);

    assign stall_o         = stall;
    assign is_branch_o     = br_ok;
    assign is_br_o         = br_ok && (opcode == OpBr);
    assign actual_taken_o  = br_ok && taken;
    assign wen_bht_o       = br_ok;
    assign wen_btb_o       = br_ok && taken;
    assign update_pc_o     = br_ok &&
                             ((taken != if_pred_taken_i) ||
                              (taken && if_pred_target_i != target));
    assign branch_target_o = target;

    assign capture     = active && !stall && !nop;
    assign id_ex_ex_d  = {src1, src2, rd1, imm, rd2, opcode, alu_src, z_en, nv_en};
    assign id_ex_mem_d = {rd2, mem_en, mem_wr};
    assign id_ex_wb_d  = {rd, reg_write, mem_to_reg, is_hlt, is_pcs};

    always_comb begin
        state_d = state_q;
        if (state_q == StRun && capture && is_hlt) begin
            state_d = StHalted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_hit) begin
            rf_q[wb_rd_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_valid_q   <= 1'b0;
            id_ex_ex_q      <= '0;
            id_ex_mem_q     <= '0;
            id_ex_wb_q      <= '0;
            id_ex_pc_next_q <= '0;
        end else if (capture) begin
            id_ex_valid_q   <= 1'b1;
            id_ex_ex_q      <= id_ex_ex_d;
            id_ex_mem_q     <= id_ex_mem_d;
            id_ex_wb_q      <= id_ex_wb_d;
            id_ex_pc_next_q <= if_pc_next_i;
        end else begin
            id_ex_valid_q   <= 1'b0;
            id_ex_ex_q      <= '0;
            id_ex_mem_q     <= '0;
            id_ex_wb_q      <= '0;
            id_ex_pc_next_q <= '0;
        end
    end

    assign id_ex_valid_o   = id_ex_valid_q;
    assign id_ex_ex_o      = id_ex_ex_q;
    assign id_ex_mem_o     = id_ex_mem_q;
    assign id_ex_wb_o      = id_ex_wb_q;
    assign id_ex_pc_next_o = id_ex_pc_next_q;
    assign halted_o        = (state_q == StHalted);

endmodule

// File: doc/pipelined_decode_stage.md
Name: pipelined_decode_stage

Overview:
Parametrised successor decode stage for the WISC pipeline. Decodes the IF/ID instruction, reads a 16-entry register file, resolves B/BR branches, and detects load-use and branch data hazards, stalling or inserting bubbles as needed. Holds the ID/EX pipeline register internally and keeps a sticky HLT state, so downstream sees registered, valid-qualified bundles.

Parameters:
DATA_W, 16, datapath/PC/register width (>=16); instruction width fixed at 16
ZERO_REG, 1, 1 = R0 reads 0 and ignores writes; 0 = R0 is ordinary

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  IF/ID holds a valid instruction
if_inst  in  16  instruction word
if_pc_next  in  DATA_W  PC+2 of instruction
if_pred_taken  in  1  predictor taken
if_pred_target  in  DATA_W  predictor target
flags  in  3  {Z,V,N}
ex_reg_wr, ex_mem_read, ex_sets_flags  in  1 each  instruction now in EX writes reg / is LW / sets any flag
ex_rd  in  4  EX destination
mem_mem_read  in  1  instruction in MEM is LW
mem_rd  in  4  MEM destination
wb_wen  in  1  register write enable
wb_rd  in  4  write register
wb_data  in  DATA_W  write data
stall  out  1  hold PC and IF/ID
is_branch, is_BR, actual_taken, wen_BTB, wen_BHT, update_PC  out  1 each  branch resolution (combinational)
branch_target  out  DATA_W  resolved target
id_ex_valid  out  1  ID/EX holds a real instruction
id_ex_ex  out  3*DATA_W+15  {SrcReg1,SrcReg2,In1,Imm,In2,ALUOp,ALUSrc,Z_en,NV_en}
id_ex_mem  out  DATA_W+2  {MemWriteData,MemEnable,MemWrite}
id_ex_wb  out  8  {rd,RegWrite,MemToReg,HLT,PCS}
id_ex_pc_next  out  DATA_W  for PCS
halted  out  1  HLT accepted

Behaviour:
- Reset: all registers 0, id_ex_* 0, halted 0, regfile all 0. Asynchronous assert; synchronous deassert handled externally.
- Opcodes: 0 ADD,1 SUB,2 XOR,3 RED,4 SLL,5 SRA,6 ROR,7 PADDSB,8 LW,9 SW,A LLB,B LHB,C B,D BR,E PCS,F HLT. 16'h0000 is NOP and is treated as a bubble.
- Sources: SrcReg1 = rd for LLB/LHB, else rs. SrcReg2 = rd for SW, else rt. Use flags: rs is used by 0-9,A,B,D; rt by 0-7 and SW(rd).
- Imm: LW/SW sign-extend imm4; shifts zero-extend imm4; LLB/LHB zero-extend imm8. ALUSrc for 4-6 and 8-B. Z_en for 0,1,2,4,5,6. NV_en for 0,1. RegWrite for 0-8,A,B,E. MemToReg for LW.
- Regfile: read is combinational; write is on posedge when wb_wen.
- Stall (combinational, only when if_valid & !halted):
  - load-use: ex_mem_read & ex_rd matches a used source (ex_rd != 0 when ZERO_REG).
  - B: ex_sets_flags.
  - BR: (ex_reg_wr & ex_rd==rs) | (mem_mem_read & mem_rd==rs).
- Branch: taken per ccc: 000 !Z; 001 Z; 010 !Z&!N; 011 N; 100 Z|(!Z&!N); 101 N|Z; 110 V; 111 1.
  - B target = if_pc_next + (sext(imm9)<<1), mod 2^DATA_W. BR target = Rs data.
  - wen_BHT = is_branch. wen_BTB = is_branch & taken.
  - update_PC = is_branch & (taken != pred_taken | (taken & pred_target != target)).
  - All branch strobes are forced to 0 during stall, when !if_valid, or when halted.
- ID/EX update, every posedge:
  - stall | !if_valid | halted | NOP -> bubble (valid 0, bundles 0).
  - otherwise -> capture decode, valid 1.
- FSM RUN/HALTED: RUN->HALTED when HLT is captured into ID/EX. HALTED is left only by reset. In HALTED, stall=0 and all inputs are ignored except register writes, which still occur.

Optional Feature:
WB_BYPASS_EN: when defined, a read of a register being written the same cycle (wb_wen, nonzero or ZERO_REG=0) returns wb_data. When undefined, the read returns the old value, and stall also asserts when wb_wen & wb_rd matches a used source.

Test Plan:
- Reset mid-run with id_ex_valid=1 -> all outputs 0 immediately. R1 write of 0x1234 then read -> 0x1234. Write R0=0x5 -> reads 0 (ZERO_REG=1).
- ADD R3,R1,R2 with R1=7, R2=9 -> next cycle id_ex_valid=1, In1=7, In2=9, wb={3,1,0,0,0}.
- ex_mem_read=1, ex_rd=2, inst SUB R4,R2,R5 -> stall=1, next ID/EX is a bubble. Release -> captured.
- B ccc=001, Z=1, imm9=0x1FE, pc_next=0x0010, pred_taken=0 -> taken=1, target=0x000C, update_PC=1, wen_BTB=1. Same with ex_sets_flags=1 -> all strobes 0, stall=1.
- HLT then ADD -> halted=1 after one cycle; ADD yields a bubble; stall stays 0.
- wb_wen R6=0xBEEF with same-cycle read of R6 -> In1=0xBEEF with WB_BYPASS_EN; stall=1 without it.
